// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads and
// buffers returned words in a small prefetch FIFO presented to decode via valid/ready.
module fetch_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 5,
    parameter int unsigned IW    = 13
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [IW-1:0]   instr_out,
    output logic [PC_W-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [IW-1:0]   instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_W-1:0]        fetch_pc_q;
    logic                   inflight_q;
    logic [PC_W-1:0]        inflight_pc_q;
    logic                   cancel_q;
    logic [CNT_W-1:0]       count_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    entry_t [DEPTH-1:0]     mem_q;

    logic                   pop;
    logic                   push;
    logic                   flush;
    logic [CNT_W-1:0]       credit;
    entry_t                 head;

    // Next-state logic; redirect does not change the mode, only halt does.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Credit counts queued, in-flight and leaving entries so a push never hits a full FIFO.
    assign head        = mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;
    assign imem_addr   = fetch_pc_q;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !cancel_q;
    assign flush       = redirect_valid && (state_q != IDLE);
    assign credit      = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    assign imem_req    = (state_q == RUN) && !redirect_valid && (credit < CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            cancel_q      <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            mem_q         <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= imem_req;
            cancel_q   <= flush && inflight_q;
            if (imem_req) begin
                fetch_pc_q    <= fetch_pc_q + PC_W'(1);
                inflight_pc_q <= fetch_pc_q;
            end
            // Redirect drops everything queued, including a response landing this cycle.
            if (flush) begin
                fetch_pc_q <= redirect_pc;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 5;
    localparam int unsigned IW    = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [IW-1:0]   instr_out;
    logic [PC_W-1:0] instr_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .IW(IW)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt)
    );

    typedef struct {
        logic [IW-1:0]   instr;
        logic [PC_W-1:0] pc;
    } ent_t;

    int              checks = 0;
    int              errors = 0;
    logic [IW-1:0]   imem [32];
    ent_t            q [$];
    bit              m_started;
    bit              m_halted;
    bit              m_inflight;
    bit              m_cancel;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ipc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_started  = 1'b0;
        m_halted   = 1'b0;
        m_inflight = 1'b0;
        m_cancel   = 1'b0;
        m_pc       = '0;
        m_ipc      = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),   32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_out"},   32'(instr_out),   32'd0);
        check({tag, "_pc"},    32'(instr_pc),    32'd0);
    endtask

    // One clock: drive inputs, compare against the model, advance the model, answer imem.
    task automatic cycle(input bit rdy, input bit rv, input logic [PC_W-1:0] rpc, input bit hl);
        bit              e_pop;
        bit              e_req;
        bit              flush;
        int              credit;
        logic            s_req;
        logic [PC_W-1:0] s_addr;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hl;
        #1;
        e_pop  = (q.size() != 0) && rdy;
        credit = q.size() + int'(m_inflight) - int'(e_pop);
        e_req  = m_started && !m_halted && !rv && (credit < int'(DEPTH));
        check("imem_req",    32'(imem_req),    32'(e_req));
        check("imem_addr",   32'(imem_addr),   32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("instr_out", 32'(instr_out), 32'(q[0].instr));
            check("instr_pc",  32'(instr_pc),  32'(q[0].pc));
        end
        s_req  = imem_req;
        s_addr = imem_addr;
        @(posedge clk);
        flush = rv && m_started;
        if (e_pop) void'(q.pop_front());
        if (flush) q.delete();
        else if (m_inflight && !m_cancel) q.push_back('{imem[m_ipc], m_ipc});
        m_cancel   = flush && m_inflight;
        m_inflight = e_req;
        if (e_req) begin
            m_ipc = m_pc;
            m_pc  = PC_W'(m_pc + 1);
        end
        if (flush) m_pc = rpc;
        if (!m_started) m_started = 1'b1;
        else m_halted = hl;
        #1 imem_rdata = s_req ? imem[s_addr] : IW'($urandom);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        bit hl;
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        imem_rdata     = IW'($urandom);
        for (int i = 0; i < 32; i++) imem[i] = IW'($urandom);
        for (int i = 0; i < 4; i++) imem[i] = IW'(13'h0101 + i);
        model_reset();
        #3 check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // T1: straight-line fetch with decode always ready
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // T2: decode stalls after restart, FIFO fills, then drains in order
        async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // T3: redirect mid-stream to 20
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, PC_W'(20), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // T4: PC wraps from 31 to 0
        cycle(1'b1, 1'b1, PC_W'(30), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // T5: halt with queued work, then resume; then redirect while halted
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, PC_W'(12), 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // T6: async reset with a full FIFO, then restart from pc 0
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        check("t6_full", 32'(q.size()), 32'(DEPTH));
        async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        // Random traffic
        hl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) hl = ~hl;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  PC_W'($urandom), hl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
